// File: rtl/comb_exerciser.sv
// Stimulus generator and 16-bit MISR response compactor for exercising a combinational block.
// Optional COMB_EXERCISER_SIG_CHECK_EN adds exp_sig input and registered pass output.
module comb_exerciser #(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 1,
  parameter int BASE_PERIOD = 5,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] run_len,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig,
  output logic [LEN_W-1:0] sample_cnt
`ifdef COMB_EXERCISER_SIG_CHECK_EN
  ,
  input  logic [15:0]      exp_sig,
  output logic             pass
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int          CW   = $clog2(N_IN * BASE_PERIOD + 1);
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam logic [15:0] POLY = 16'h1021;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sig_q, sig_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    tcnt_q [N_IN];
  logic [CW-1:0]    tcnt_d [N_IN];
  logic [LEN_W-1:0] cnt_inc;
  logic [15:0]      sig_next;
`ifdef COMB_EXERCISER_SIG_CHECK_EN
  logic             pass_q, pass_d;
`endif

  function automatic logic [CW-1:0] reload_val(input int i);
    return CW'((i + 1) * BASE_PERIOD - 1);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [N_OUT-1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ 16'(r);
  endfunction

  // The run index t always equals the sample count, so one counter serves both.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tcnt_d   = tcnt_q;
    cnt_inc  = cnt_q + LEN_W'(1);
    sig_next = misr_step(sig_q, resp);
`ifdef COMB_EXERCISER_SIG_CHECK_EN
    pass_d   = pass_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '0;
        if (start) begin
          mode_d = mode;
          len_d  = run_len;
          sig_d  = SEED;
          cnt_d  = '0;
          for (int i = 0; i < N_IN; i++) tcnt_d[i] = reload_val(i);
`ifdef COMB_EXERCISER_SIG_CHECK_EN
          pass_d = 1'b0;
`endif
          if (run_len != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef COMB_EXERCISER_SIG_CHECK_EN
            pass_d  = (SEED == exp_sig);
`endif
          end
        end
      end

      RUN: begin
        sig_d = sig_next;
        cnt_d = cnt_inc;
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          stim_d  = '0;
`ifdef COMB_EXERCISER_SIG_CHECK_EN
          pass_d  = (sig_next == exp_sig);
`endif
        end else if (mode_q) begin
          stim_d = N_IN'(cnt_inc);
        end else begin
          // Each bit owns a down-counter that flips it and reloads on expiry.
          for (int i = 0; i < N_IN; i++) begin
            if (tcnt_q[i] == '0) begin
              stim_d[i] = ~stim_q[i];
              tcnt_d[i] = reload_val(i);
            end else begin
              tcnt_d[i] = tcnt_q[i] - CW'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= SEED;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) tcnt_q[i] <= '0;
`ifdef COMB_EXERCISER_SIG_CHECK_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < N_IN; i++) tcnt_q[i] <= tcnt_d[i];
`ifdef COMB_EXERCISER_SIG_CHECK_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sig        = sig_q;
  assign sample_cnt = cnt_q;
`ifdef COMB_EXERCISER_SIG_CHECK_EN
  assign pass       = pass_q;
`endif

endmodule
